outarb: RTL
===========

# outarb

Per-output-channel packet arbiter for the router. Shares one output physical channel among `NPORT` input ports using round-robin selection, and locks the channel to the winner from head flit to tail flit. A head flit is granted only when its requested output VC has room for a full packet (`ordy`) and is not locked (`olck`). The registered grant and mux select drive the crossbar stage in front of the output channel.

## Interface
Parameters:
- `ROUTERID`, 0, router identifier (debug only)
- `PCHID`, 0, physical output channel served
- `NPORT`, 5, number of requesting input ports
- `NVCH`, 2, virtual channels on the output channel
- `VCHW`, 1, VC index width minus 1

Ports:
- `clk`  in  1  sole clock; all state on rising edge
- `rst_`  in  1  asynchronous, active-high reset
- `ireq`  in  NPORT  port i presents a valid flit routed to this channel
- `ivch`  in  NPORT*(VCHW+1)  requested output VC per port (slice i)
- `itype`  in  NPORT*(TYPEW+1)  flit type per port: HEAD, BODY, TAIL, HEADTAIL
- `ordy`  in  NVCH  VC has space for a whole packet
- `olck`  in  NVCH  VC currently locked downstream
- `ogrant`  out  NPORT  registered one-hot grant
- `osel`  out  clog2(NPORT)  encoded index of the granted port
- `ovch`  out  VCHW+1  output VC of the packet in flight
- `obusy`  out  1  a packet currently holds the channel

## Operation
- States: IDLE, HOLD.
- Eligibility in IDLE: port i is eligible when `ireq[i]`, `itype[i]` is HEAD or HEADTAIL, `ordy[ivch_i]` = 1 and `olck[ivch_i]` = 0. BODY and TAIL flits from ungranted ports are ignored.
- Round-robin: search starts at `ptr`, index increases, wraps at NPORT-1 to 0, and the first eligible port wins.
- IDLE with a winner w: next state is HOLD, `ogrant` = 1<<w, `osel` = w, `ovch` = `ivch_w`, `obusy` = 1.
- IDLE with no winner: the block stays in IDLE and all outputs stay 0.
- Transfer: occurs in any cycle where `ogrant[w]` and `ireq[w]` are both 1.
- Release: a transfer whose `itype[w]` is TAIL or HEADTAIL releases the channel.
  - Next state is IDLE and `ptr` becomes (w+1) mod NPORT.
  - `ogrant`, `osel`, `ovch` and `obusy` clear next cycle.
- HOLD with `ireq[w]` = 0 (bubble): the grant is held indefinitely.
- A HEAD from w while in HOLD is a protocol error; it is treated as BODY and the grant is held.
- `ordy`/`olck` changes during HOLD do not affect the grant. Flow control inside the packet belongs to the output channel.
- Requests from other ports during HOLD have no effect. Their eligibility is re-evaluated on return to IDLE.

## Timing
- Reset (async assert, sync release): state IDLE, `ptr` = 0, `ogrant` = 0, `osel` = 0, `ovch` = 0, `obusy` = 0.
- Reset mid-packet drops the grant immediately. No flit is emitted after reset.
- Grant latency: eligible head at cycle t gives `ogrant` at t+1. The head flit transfers at t+1.
- HEADTAIL packet: grant held exactly one cycle (t+1) and released at t+2.
- Packet-to-packet gap without the macro: one IDLE cycle between release and the next grant. The next grant can be visible at the earliest at release+1.
- Simultaneous eligible heads: the lowest index at or after `ptr` (mod NPORT) wins.

## Configuration
- `OUTARB_FASTARB_EN` defined: on the release cycle, arbitration runs in the same cycle.
  - Eligibility uses current `ordy`/`olck`.
  - The releasing port is excluded; the search starts at w+1.
  - A new winner's grant appears at release+1 with no idle cycle, and the state stays HOLD.
- `OUTARB_FASTARB_EN` undefined: behaviour is exactly as in Timing, with a mandatory one-cycle gap.

## Structure
- `define.h` additions:
  - Flit type encodings `TYPE_HEAD`, `TYPE_BODY`, `TYPE_TAIL`, `TYPE_HEADTAIL`, `TYPE_NONE`, plus `TYPEW` (shared with the channel blocks).
  - `Enable`/`Disable` constants.
  - State encodings `OUTARB_IDLE`, `OUTARB_HOLD`.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: eligible vector, `ptr`.
  - Outputs: one-hot winner, encoded index, found flag.
  - Reused by other allocators.

## Test plan
- Single HEADTAIL on port 2 to VC 0, `ordy` = 01, `olck` = 00 → `ogrant` = 00100 for one cycle, `ptr` = 3 afterwards.
- Ports 0 and 3 request HEAD simultaneously with `ptr` = 1 → port 3 granted first. After its TAIL, port 0 is granted (one-cycle gap, or zero gap with the macro).
- Port 1 HEAD to VC 1 with `olck[1]` = 1 → no grant. Drop `olck[1]` → grant next cycle.
- Four-flit packet on port 4 with a two-cycle `ireq` bubble after the head → grant held for the whole packet, released one cycle after the TAIL transfer, and no other port granted meanwhile.
- Assert `rst_` during HOLD on port 2 → `ogrant` = 0 and `obusy` = 0 immediately. After release, the first request from any port sees `ptr` = 0.
- BODY flit on port 0 while in IDLE and eligible HEAD on port 1 → port 1 granted, port 0 ignored.

Source files
------------

// File: rtl/outarb_pkg.sv
// outarb_pkg: shared definitions for the output-channel arbiter and the
// channel blocks that exchange flits with it.
//   - Flit type encodings TYPE_* and the type field width TYPEW (width-1)
//   - ENABLE / DISABLE single-bit constants
//   - Arbiter state encodings OUTARB_IDLE / OUTARB_HOLD
//   - is_head / is_tail flit-type helpers
package outarb_pkg;

    localparam int TYPEW = 2;

    localparam logic [TYPEW:0] TYPE_NONE     = 3'd0;
    localparam logic [TYPEW:0] TYPE_HEAD     = 3'd1;
    localparam logic [TYPEW:0] TYPE_BODY     = 3'd2;
    localparam logic [TYPEW:0] TYPE_TAIL     = 3'd3;
    localparam logic [TYPEW:0] TYPE_HEADTAIL = 3'd4;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic {
        OUTARB_IDLE = 1'b0,
        OUTARB_HOLD = 1'b1
    } outarb_state_t;

    // A flit that opens a packet.
    function automatic logic is_head(input logic [TYPEW:0] t);
        return (t == TYPE_HEAD) || (t == TYPE_HEADTAIL);
    endfunction

    // A flit that closes a packet.
    function automatic logic is_tail(input logic [TYPEW:0] t);
        return (t == TYPE_TAIL) || (t == TYPE_HEADTAIL);
    endfunction

endpackage

// File: rtl/outarb_rr_pick.sv
// outarb_rr_pick: combinational round-robin picker, reusable by any allocator.
// Starting at index ptr and moving upward with wrap from N-1 to 0, the first
// set bit of elig wins.
// Parameters: N  number of requesters
//             W  width of ptr / idx
// Ports:
//   elig    in  N  eligible requesters
//   ptr     in  W  index where the search starts (must be < N)
//   onehot  out N  one-hot winner (0 when none)
//   idx     out W  encoded winner (0 when none)
//   found   out 1  a winner exists
module outarb_rr_pick
    import outarb_pkg::*;
#(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         found
);

    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = DISABLE;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && elig[j]) begin
                found     = ENABLE;
                onehot[j] = 1'b1;
                idx       = W'(j);
            end
        end
    end

endmodule

// File: rtl/outarb.sv
// outarb: per-output-channel packet arbiter.
// Shares one output physical channel among NPORT input ports with round-robin
// selection and locks the channel to the winner from head flit to tail flit.
// A head is only granted when its requested VC has room for a whole packet
// (ordy) and is not locked downstream (olck).
//
// Compile-time option: OUTARB_FASTARB_EN
//   defined   - on a release cycle a new winner is picked in the same cycle
//               (releasing port excluded, search from w+1), so back-to-back
//               packets have no idle cycle.
//   undefined - one IDLE cycle always separates release and the next grant.
//
// Ports:
//   clk     in   1                 clock, rising edge
//   rst_    in   1                 asynchronous active-high reset
//   ireq    in   NPORT             port i presents a flit for this channel
//   ivch    in   NPORT*(VCHW+1)    requested output VC, slice i
//   itype   in   NPORT*(TYPEW+1)   flit type, slice i
//   ordy    in   NVCH              VC has room for a whole packet
//   olck    in   NVCH              VC locked downstream
//   ogrant  out  NPORT             registered one-hot grant
//   osel    out  clog2(NPORT)      index of the granted port
//   ovch    out  VCHW+1            output VC of the packet in flight
//   obusy   out  1                 a packet holds the channel
module outarb
    import outarb_pkg::*;
#(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int NPORT    = 5,
    parameter int NVCH     = 2,
    parameter int VCHW     = 1,
    localparam int SELW    = $clog2(NPORT)
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic [NPORT-1:0]           ireq,
    input  logic [NPORT*(VCHW+1)-1:0]  ivch,
    input  logic [NPORT*(TYPEW+1)-1:0] itype,
    input  logic [NVCH-1:0]            ordy,
    input  logic [NVCH-1:0]            olck,
    output logic [NPORT-1:0]           ogrant,
    output logic [SELW-1:0]            osel,
    output logic [VCHW:0]              ovch,
    output logic                       obusy
);

    // ROUTERID / PCHID only tag the instance for debug; negative values are
    // meaningless and leave this marker block in the elaborated hierarchy.
    if (ROUTERID < 0 || PCHID < 0) begin : g_bad_debug_id
    end

    logic [VCHW:0]      vch_a  [NPORT];
    logic [TYPEW:0]     type_a [NPORT];
    logic [NPORT-1:0]   elig;
    logic [NPORT-1:0]   pick_elig;
    logic [NPORT-1:0]   pick_oh;
    logic [SELW-1:0]    pick_ptr;
    logic [SELW-1:0]    pick_idx;
    logic               pick_found;

    outarb_state_t      state_q, state_d;
    logic [SELW-1:0]    ptr_q, ptr_d;
    logic [NPORT-1:0]   grant_q, grant_d;
    logic [SELW-1:0]    sel_q, sel_d;
    logic [VCHW:0]      vch_q, vch_d;

    logic [TYPEW:0]     type_w;
    logic [SELW-1:0]    ptr_w1;
    logic               xfer;
    logic               rel;

    function automatic logic [SELW-1:0] inc_mod(input logic [SELW-1:0] v);
        return (v == SELW'(NPORT - 1)) ? '0 : v + 1'b1;
    endfunction

    // Split the flat per-port buses.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            vch_a[i]  = ivch[i*(VCHW+1) +: (VCHW+1)];
            type_a[i] = itype[i*(TYPEW+1) +: (TYPEW+1)];
        end
    end

    // Head flits whose target VC can take a whole packet and is unlocked.
    // VC indices beyond NVCH never match and so are never eligible.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NPORT; i++) begin
            for (int v = 0; v < NVCH; v++) begin
                if (ireq[i] && is_head(type_a[i]) && (int'(vch_a[i]) == v) &&
                    ordy[v] && !olck[v])
                    elig[i] = 1'b1;
            end
        end
    end

    // Flit of the granted port while a transfer happens. A HEAD arriving
    // inside a packet is a protocol error and is handled as a BODY.
    always_comb begin
        xfer = (state_q == OUTARB_HOLD) && ireq[sel_q];
        if (!xfer)
            type_w = TYPE_NONE;
        else if (type_a[sel_q] == TYPE_HEAD)
            type_w = TYPE_BODY;
        else
            type_w = type_a[sel_q];
        rel    = xfer && is_tail(type_w);
        ptr_w1 = inc_mod(sel_q);
    end

`ifdef OUTARB_FASTARB_EN
    // On a release the search starts just after the releasing port and the
    // releasing port itself is masked out.
    always_comb begin
        if (state_q == OUTARB_HOLD) begin
            pick_ptr  = ptr_w1;
            pick_elig = elig & ~grant_q;
        end else begin
            pick_ptr  = ptr_q;
            pick_elig = elig;
        end
    end
`else
    always_comb begin
        pick_ptr  = ptr_q;
        pick_elig = elig;
    end
`endif

    outarb_rr_pick #(
        .N (NPORT),
        .W (SELW)
    ) u_pick (
        .elig   (pick_elig),
        .ptr    (pick_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        vch_d   = vch_q;
        unique case (state_q)
            OUTARB_IDLE: begin
                if (pick_found) begin
                    state_d = OUTARB_HOLD;
                    grant_d = pick_oh;
                    sel_d   = pick_idx;
                    vch_d   = vch_a[pick_idx];
                end else begin
                    grant_d = '0;
                    sel_d   = '0;
                    vch_d   = '0;
                end
            end
            OUTARB_HOLD: begin
                // Bubbles, other requesters and ordy/olck changes are ignored
                // until the tail of the current packet transfers.
                if (rel) begin
                    state_d = OUTARB_IDLE;
                    ptr_d   = ptr_w1;
                    grant_d = '0;
                    sel_d   = '0;
                    vch_d   = '0;
`ifdef OUTARB_FASTARB_EN
                    if (pick_found) begin
                        state_d = OUTARB_HOLD;
                        grant_d = pick_oh;
                        sel_d   = pick_idx;
                        vch_d   = vch_a[pick_idx];
                    end
`endif
                end
            end
            default: state_d = OUTARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q <= OUTARB_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            sel_q   <= '0;
            vch_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            vch_q   <= vch_d;
        end
    end

    assign ogrant = grant_q;
    assign osel   = sel_q;
    assign ovch   = vch_q;
    assign obusy  = (state_q == OUTARB_HOLD);

endmodule
